ccastles_vram_arbiter: RTL and testbench

Time-slot arbiter for the Crystal Castles 64K video/work DRAM. It shares the single RAM port between three requesters: the video fetch (scan-out), the 6502 CPU (direct and bit-mode pixel writes) and a DRAM refresh generator. It sits between the CPU address decoder and the video shifter, on the 10 MHz system clock, and drives the RAM model.

---
 rtl/ccastles_pkg.sv | 15 +
 rtl/ccastles_refresh_timer.sv | 33 +++
 rtl/ccastles_vram_arbiter.sv | 124 ++++++++++++
 tb/tb_ccastles_vram_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ccastles_pkg.sv
// ccastles_pkg: slot owner type and window phase constants for the VRAM arbiter
package ccastles_pkg;

  typedef enum logic [1:0] {NONE, VID, CPU, REF} slot_owner_t;

  localparam logic [1:0] PH_VID  = 2'd0;
  localparam logic [1:0] PH_VCAP = 2'd1;
  localparam logic [1:0] PH_CPU  = 2'd2;
  localparam logic [1:0] PH_CCAP = 2'd3;

  function automatic logic is_ram_owner(input slot_owner_t o);
    return o == VID || o == CPU;
  endfunction

endpackage

// File: rtl/ccastles_refresh_timer.sv
// ccastles_refresh_timer: counts windows and raises refresh pending/urgent until serviced
module ccastles_refresh_timer #(
  parameter int REFRESH_DIV = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic win_end,
  input  logic service,
  output logic pending,
  output logic urgent
);

  localparam int TW = $clog2(REFRESH_DIV);

  logic [TW-1:0] timer;
  logic          tick;

  assign tick = win_end && timer == TW'(REFRESH_DIV - 1);

  // window divider; a tick on an already pending refresh escalates to urgent, more ticks are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      timer   <= '0;
      pending <= 1'b0;
      urgent  <= 1'b0;
    end else begin
      timer   <= win_end ? (tick ? '0 : timer + 1'b1) : timer;
      pending <= service ? 1'b0 : (pending | tick);
      urgent  <= service ? 1'b0 : (urgent | (tick & pending));
    end
  end

endmodule

// File: rtl/ccastles_vram_arbiter.sv
// ccastles_vram_arbiter: 4-clock time-slot arbiter sharing one DRAM port between video, CPU and refresh
// Optional nibble (bit-mode) CPU writes are enabled by defining CCASTLES_BITMODE_EN.
module ccastles_vram_arbiter
  import ccastles_pkg::*;
#(
  parameter int REFRESH_DIV = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_bitmd,
  input  logic        cpu_pixb,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        ram_en,
  output logic        ram_we,
  output logic [1:0]  ram_nwe,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        ram_refresh,
  output logic [7:0]  refresh_row
);

  logic [1:0]  ph;
  slot_owner_t owner;
  slot_owner_t next_owner;
  logic        pending;
  logic        urgent;
  logic        cpu_wr;
  logic [1:0]  wr_nwe;
  logic [7:0]  wr_data;

  ccastles_refresh_timer #(.REFRESH_DIV(REFRESH_DIV)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .win_end (ph == PH_CCAP),
    .service (next_owner == REF),
    .pending (pending),
    .urgent  (urgent)
  );

`ifdef CCASTLES_BITMODE_EN
  assign wr_nwe  = cpu_bitmd ? (cpu_pixb ? 2'b10 : 2'b01) : 2'b11;
  assign wr_data = cpu_bitmd ? {2{cpu_wdata[3:0]}} : cpu_wdata;
`else
  logic bitmode_unused;
  assign bitmode_unused = cpu_bitmd ^ cpu_pixb;
  assign wr_nwe  = 2'b11;
  assign wr_data = cpu_wdata;
`endif

  // slot decision: video slot falls back to refresh, an urgent refresh steals the CPU slot
  always_comb begin
    next_owner = NONE;
    if (ph == PH_VID)
      next_owner = vid_req ? VID : (pending ? REF : NONE);
    else if (ph == PH_CPU)
      next_owner = urgent ? REF : (cpu_req ? CPU : (pending ? REF : NONE));
  end

  assign cpu_wr = next_owner == CPU && cpu_we;

  // phase counter and owner of the access currently on the RAM port
  always_ff @(posedge clk) begin
    if (reset) begin
      ph    <= PH_VID;
      owner <= NONE;
    end else begin
      ph    <= ph + 2'd1;
      owner <= next_owner;
    end
  end

  // RAM port strobes for one clock; address and write data hold between accesses
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_nwe     <= 2'b00;
      ram_refresh <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
    end else begin
      ram_en      <= is_ram_owner(next_owner);
      ram_we      <= cpu_wr;
      ram_nwe     <= cpu_wr ? wr_nwe : 2'b00;
      ram_refresh <= next_owner == REF;
      ram_addr    <= next_owner == VID ? vid_addr : (next_owner == CPU ? cpu_addr : ram_addr);
      ram_wdata   <= cpu_wr ? wr_data : ram_wdata;
    end
  end

  // capture phase: return read data to the requester that owned the previous clock
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_valid <= 1'b0;
      vid_data  <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      vid_valid <= ph == PH_VCAP && owner == VID;
      vid_data  <= (ph == PH_VCAP && owner == VID) ? ram_rdata : vid_data;
      cpu_ack   <= ph == PH_CCAP && owner == CPU;
      cpu_rdata <= (ph == PH_CCAP && owner == CPU && !ram_we) ? ram_rdata : cpu_rdata;
    end
  end

  // refresh row advances once per serviced refresh slot
  always_ff @(posedge clk) begin
    if (reset)
      refresh_row <= '0;
    else
      refresh_row <= next_owner == REF ? refresh_row + 8'd1 : refresh_row;
  end

endmodule

// File: tb/tb_ccastles_vram_arbiter.sv
// tb_ccastles_vram_arbiter: directed and random checks of the VRAM arbiter against a slot-rule model
module tb_ccastles_vram_arbiter;

  localparam int DIV = 2;
  localparam int O_NONE = 0;
  localparam int O_VID  = 1;
  localparam int O_CPU  = 2;
  localparam int O_REF  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_bitmd = 1'b0;
  logic        cpu_pixb = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        ram_en;
  logic        ram_we;
  logic [1:0]  ram_nwe;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_refresh;
  logic [7:0]  refresh_row;

  logic [7:0] ram [65536];
  logic [7:0] mdl [65536];

  int checks = 0;
  int failures = 0;

  int          e;
  int          last_owner;
  logic [15:0] last_addr;
  logic        last_we;
  logic        pend;
  logic        urg;
  logic        x_vid_valid, x_cpu_ack, x_ram_en, x_ram_we, x_ram_refresh;
  logic [1:0]  x_ram_nwe;
  logic [7:0]  x_vid_data, x_cpu_rdata, x_ram_wdata, x_row;
  logic [15:0] x_ram_addr;

  ccastles_vram_arbiter #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .vid_valid   (vid_valid),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_bitmd   (cpu_bitmd),
    .cpu_pixb    (cpu_pixb),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_nwe     (ram_nwe),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_refresh (ram_refresh),
    .refresh_row (refresh_row)
  );

  always #50 clk = ~clk;

  assign ram_rdata = ram[ram_addr];

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      if (ram_nwe[1]) ram[ram_addr][7:4] <= ram_wdata[7:4];
      if (ram_nwe[0]) ram[ram_addr][3:0] <= ram_wdata[3:0];
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // predicts the outputs following the next rising edge from the current inputs
  task automatic model_edge();
    int ph;
    int own;
    logic [7:0] wd;
    logic [1:0] nwe;
    own = O_NONE;
    x_vid_valid = 0; x_cpu_ack = 0; x_ram_en = 0; x_ram_we = 0; x_ram_nwe = 0; x_ram_refresh = 0;
    if (reset) begin
      e = 0; pend = 0; urg = 0; last_owner = O_NONE; last_we = 0; last_addr = 0;
      x_vid_data = 0; x_cpu_rdata = 0; x_ram_addr = 0; x_ram_wdata = 0; x_row = 0;
      return;
    end
    ph = e % 4;
    if (ph == 1 && last_owner == O_VID) begin x_vid_valid = 1; x_vid_data = mdl[last_addr]; end
    if (ph == 3 && last_owner == O_CPU) begin x_cpu_ack = 1; if (!last_we) x_cpu_rdata = mdl[last_addr]; end
    if (ph == 0) own = vid_req ? O_VID : (pend ? O_REF : O_NONE);
    if (ph == 2) own = urg ? O_REF : (cpu_req ? O_CPU : (pend ? O_REF : O_NONE));
    if (own == O_VID) begin
      x_ram_en = 1; x_ram_addr = vid_addr; last_addr = vid_addr;
    end else if (own == O_CPU) begin
      x_ram_en = 1; x_ram_addr = cpu_addr; last_addr = cpu_addr; last_we = cpu_we;
      if (cpu_we) begin
        wd = cpu_wdata; nwe = 2'b11;
`ifdef CCASTLES_BITMODE_EN
        if (cpu_bitmd) begin wd = {cpu_wdata[3:0], cpu_wdata[3:0]}; nwe = cpu_pixb ? 2'b10 : 2'b01; end
`endif
        x_ram_we = 1; x_ram_nwe = nwe; x_ram_wdata = wd;
        if (nwe[1]) mdl[cpu_addr][7:4] = wd[7:4];
        if (nwe[0]) mdl[cpu_addr][3:0] = wd[3:0];
      end
    end else if (own == O_REF) begin
      x_ram_refresh = 1; x_row = x_row + 8'd1; pend = 0; urg = 0;
    end
    if (ph == 3 && ((e / 4 + 1) % DIV) == 0) begin
      if (pend) urg = 1;
      pend = 1;
    end
    last_owner = own;
    e++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("vid_valid", 16'(vid_valid), 16'(x_vid_valid));
    check("vid_data", 16'(vid_data), 16'(x_vid_data));
    check("cpu_ack", 16'(cpu_ack), 16'(x_cpu_ack));
    check("cpu_rdata", 16'(cpu_rdata), 16'(x_cpu_rdata));
    check("ram_en", 16'(ram_en), 16'(x_ram_en));
    check("ram_we", 16'(ram_we), 16'(x_ram_we));
    check("ram_nwe", 16'(ram_nwe), 16'(x_ram_nwe));
    check("ram_addr", ram_addr, x_ram_addr);
    check("ram_wdata", 16'(ram_wdata), 16'(x_ram_wdata));
    check("ram_refresh", 16'(ram_refresh), 16'(x_ram_refresh));
    check("refresh_row", 16'(refresh_row), 16'(x_row));
  endtask

  initial begin
    int n;
    int ref_at;
    int nref;
    logic a19, a23;
    logic [7:0] r255;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'(i ^ (i >> 8) ^ 8'h5A);
      mdl[i] = ram[i];
    end
    ram[16'h1234] = 8'hA5; mdl[16'h1234] = 8'hA5;
    ram[16'h8000] = 8'h3C; mdl[16'h8000] = 8'h3C;

    reset = 1; vid_req = 1; cpu_req = 1; cpu_we = 1; cpu_bitmd = 1; cpu_pixb = 1;
    vid_addr = 16'h1234; cpu_addr = 16'h8000; cpu_wdata = 8'hFF;
    repeat (3) step();
    check("reset_ram_en", 16'(ram_en), 16'd0);
    check("reset_row", 16'(refresh_row), 16'd0);
    reset = 0; cpu_req = 0; cpu_we = 0; cpu_bitmd = 0; cpu_pixb = 0;
    step();
    check("first_en_ph0", 16'(ram_en), 16'd1);
    check("vid_addr_out", ram_addr, 16'h1234);
    vid_req = 0;
    step();
    check("vid_valid_ph1", 16'(vid_valid), 16'd1);
    check("vid_data_a5", 16'(vid_data), 16'hA5);

    while (e % 4 != 3) step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h8000;
    n = 0;
    do begin step(); n++; end while (!cpu_ack && n < 12);
    check("cpu_read_latency", 16'(n - 1), 16'd4);
    check("cpu_rdata_3c", 16'(cpu_rdata), 16'h3C);
    cpu_req = 0;

    while (e % 4 != 2) step();
    cpu_req = 1; cpu_we = 1; cpu_bitmd = 1; cpu_pixb = 1; cpu_addr = 16'h4000; cpu_wdata = 8'h07;
    step();
`ifdef CCASTLES_BITMODE_EN
    check("bitmd_nwe", 16'(ram_nwe), 16'd2);
    check("bitmd_wdata", 16'(ram_wdata), 16'h77);
`else
    check("bitmd_nwe", 16'(ram_nwe), 16'd3);
    check("bitmd_wdata", 16'(ram_wdata), 16'h07);
`endif
    step();
    check("write_ack", 16'(cpu_ack), 16'd1);
    cpu_req = 0; cpu_we = 0; cpu_bitmd = 0; cpu_pixb = 0;
    vid_req = 1; vid_addr = 16'h4000;
    repeat (2) step();
    vid_req = 0;

    reset = 1; vid_req = 1; cpu_req = 1;
    step();
    reset = 0; vid_addr = 16'h0010; cpu_addr = 16'h0020;
    ref_at = -1; a19 = 0; a23 = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (ram_refresh && ref_at < 0) ref_at = i;
      if (i == 19) a19 = cpu_ack;
      if (i == 23) a23 = cpu_ack;
    end
    check("steal_edge", 16'(ref_at), 16'd18);
    check("ack_stolen", 16'(a19), 16'd0);
    check("ack_delayed", 16'(a23), 16'd1);
    check("steal_row", 16'(refresh_row), 16'd1);

    reset = 1; vid_req = 0; cpu_req = 0;
    step();
    reset = 0;
    nref = 0; n = 0; r255 = 0;
    while (nref < 256 && n < 2400) begin
      step();
      n++;
      if (ram_refresh) begin
        nref++;
        if (nref == 255) r255 = refresh_row;
      end
    end
    check("refresh_count", 16'(nref), 16'd256);
    check("row_255", 16'(r255), 16'd255);
    check("row_wrap", 16'(refresh_row), 16'd0);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 400) == 0;
      vid_req = ($urandom % 3) != 0;
      vid_addr = 16'h00F0 + 16'($urandom_range(0, 15));
      if (cpu_req && cpu_ack) cpu_req = 0;
      else if (!cpu_req) begin
        if (($urandom % 3) == 0) begin
          cpu_req = 1; cpu_we = 1'($urandom); cpu_bitmd = 1'($urandom); cpu_pixb = 1'($urandom);
          cpu_addr = 16'h00F0 + 16'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
        end
      end else if (($urandom % 16) == 0) cpu_req = 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
